// File: rtl/joy_dir_filter.sv
// joy_dir_filter: per-player joystick direction conditioner.
// Each player gets its own channel: 2-flop sync, per-bit debounce,
// optional SOCD cleaning, rising-edge detect and a mode-driven selector.

module joy_dir_chan #(
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic       i_socd_en,
    input  logic [1:0] i_mode,
    input  logic [3:0] i_dir,
    output logic [3:0] o_dir
);

    typedef enum logic [1:0] {
        M_PASS  = 2'd0,
        M_LAST  = 2'd1,
        M_FIRST = 2'd2,
        M_HORIZ = 2'd3
    } mode_e;

    // One-hot of the highest set bit, priority up > down > left > right.
    function automatic logic [3:0] hp(input logic [3:0] x);
        casez (x)
            4'b1???: hp = 4'b1000;
            4'b01??: hp = 4'b0100;
            4'b001?: hp = 4'b0010;
            4'b0001: hp = 4'b0001;
            default: hp = 4'b0000;
        endcase
    endfunction

    logic [3:0] r_s1, r_s2, r_st, r_fp, r_sel;
    mode_e      r_mode_q;
    mode_e      w_mode;
    logic [3:0] w_f, w_new, w_mask, w_g, w_ng, w_last, w_first;

    assign w_mode = mode_e'(i_mode);

    // Two-flop synchroniser for the raw joystick bits.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_dir;
            r_s2 <= r_s1;
        end
    end

    generate
        if (DEBOUNCE_CNT == 0) begin : g_nodb
            // ce has no role without debounce; the register keeps latency uniform.
            logic w_unused_ce;
            assign w_unused_ce = i_ce;

            // Stable value simply follows the synchroniser.
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) r_st <= '0;
                else            r_st <= r_s2;
            end
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CNT + 1);
            localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CNT - 1);
            logic [3:0][CW-1:0] r_cnt;

            // Per-bit debounce: st moves only after DEBOUNCE_CNT consecutive ce ticks of disagreement.
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    r_st  <= '0;
                    r_cnt <= '0;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_s2[b] == r_st[b]) begin
                            r_cnt[b] <= '0;
                        end else if (i_ce) begin
                            if (r_cnt[b] == CMAX) begin
                                r_st[b]  <= r_s2[b];
                                r_cnt[b] <= '0;
                            end else begin
                                r_cnt[b] <= r_cnt[b] + CW'(1);
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // SOCD cleaning: opposing pairs pressed together cancel out.
    always_comb begin
        w_f = r_st;
        if (i_socd_en) begin
            if (r_st[3] && r_st[2]) w_f[3:2] = 2'b00;
            if (r_st[1] && r_st[0]) w_f[1:0] = 2'b00;
        end
    end

    // Candidate selections for each restricting mode.
    always_comb begin
        w_new   = w_f & ~r_fp;
        w_mask  = (w_mode == M_HORIZ) ? 4'b0011 : 4'b1111;
        w_g     = w_f & w_mask;
        w_ng    = w_new & w_mask;
        w_last  = (w_ng != 4'b0000)        ? hp(w_ng) :
                  ((w_g & r_sel) == 4'b0000) ? hp(w_g)  : r_sel;
        w_first = ((w_f & r_sel) != 4'b0000) ? r_sel : hp(w_f);
    end

    // Edge-detect history, selector register and mode tracking.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_fp     <= '0;
            r_sel    <= '0;
            r_mode_q <= M_PASS;
        end else begin
            r_fp <= w_f;
            if (w_mode != r_mode_q) begin
                r_sel    <= (w_mode == M_PASS) ? w_f : hp(w_g);
                r_mode_q <= w_mode;
            end else begin
                case (w_mode)
                    M_PASS:  r_sel <= w_f;
                    M_FIRST: r_sel <= w_first;
                    default: r_sel <= w_last;
                endcase
            end
        end
    end

    assign o_dir = r_sel;

endmodule

module joy_dir_filter #(
    parameter int NUM_PLAYERS  = 2,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_ce,
    input  logic                     i_socd_en,
    input  logic [2*NUM_PLAYERS-1:0] i_mode,
    input  logic [4*NUM_PLAYERS-1:0] i_dir_in,
    output logic [4*NUM_PLAYERS-1:0] o_dir_out
);

    logic [NUM_PLAYERS-1:0][1:0] w_mode;
    logic [NUM_PLAYERS-1:0][3:0] w_dir_in;
    logic [NUM_PLAYERS-1:0][3:0] w_dir_out;

    assign w_mode    = i_mode;
    assign w_dir_in  = i_dir_in;
    assign o_dir_out = w_dir_out;

    generate
        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_chan
            joy_dir_chan #(
                .DEBOUNCE_CNT(DEBOUNCE_CNT)
            ) u_chan (
                .i_clk    (i_clk),
                .i_reset_n(i_reset_n),
                .i_ce     (i_ce),
                .i_socd_en(i_socd_en),
                .i_mode   (w_mode[p]),
                .i_dir    (w_dir_in[p]),
                .o_dir    (w_dir_out[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: two DUTs (no debounce, debounce of 3) share stimulus;
// a cycle model checks every cycle, literal checks pin the model.

module tb_joy_dir_filter;

    logic       clk = 1'b0;
    logic       rst_n, ce, socd;
    logic [3:0] mode;
    logic [7:0] din;
    logic [7:0] out0, out3;

    always #5 clk = ~clk;

    joy_dir_filter #(.NUM_PLAYERS(2), .DEBOUNCE_CNT(0)) u_d0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_socd_en(socd),
        .i_mode(mode), .i_dir_in(din), .o_dir_out(out0));

    joy_dir_filter #(.NUM_PLAYERS(2), .DEBOUNCE_CNT(3)) u_d3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_socd_en(socd),
        .i_mode(mode), .i_dir_in(din), .o_dir_out(out3));

    int nvec = 0;
    int nerr = 0;
    bit run  = 0;
    int cyc  = 0;
    bit ce_free = 1;
    bit ce_rand = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] mhp(input logic [3:0] x);
        for (int i = 3; i >= 0; i--) if (x[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    logic [3:0] ms1[2][2], ms2[2][2], mst[2][2], mfp[2][2], msel[2][2];
    logic [1:0] mmq[2][2];
    int         mcnt[2][2][4];
    logic [3:0] mf, mnw, mg, mng, mmsk;
    logic [1:0] mmd;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rst_n) begin
                    ms1[k][p] = 0; ms2[k][p] = 0; mst[k][p] = 0;
                    mfp[k][p] = 0; msel[k][p] = 0; mmq[k][p] = 0;
                    for (int b = 0; b < 4; b++) mcnt[k][p][b] = 0;
                end else begin
                    mmd = mode[2*p +: 2];
                    mf  = mst[k][p];
                    if (socd) begin
                        if (mf[3] && mf[2]) mf[3:2] = 2'b00;
                        if (mf[1] && mf[0]) mf[1:0] = 2'b00;
                    end
                    mnw  = mf & ~mfp[k][p];
                    mmsk = (mmd == 2'd3) ? 4'b0011 : 4'b1111;
                    mg   = mf & mmsk;
                    mng  = mnw & mmsk;
                    if (mmd != mmq[k][p]) begin
                        msel[k][p] = (mmd == 2'd0) ? mf : mhp(mg);
                        mmq[k][p]  = mmd;
                    end else if (mmd == 2'd0) begin
                        msel[k][p] = mf;
                    end else if (mmd == 2'd2) begin
                        if ((mf & msel[k][p]) == 0) msel[k][p] = mhp(mf);
                    end else begin
                        if (mng != 0) msel[k][p] = mhp(mng);
                        else if ((mg & msel[k][p]) == 0) msel[k][p] = mhp(mg);
                    end
                    mfp[k][p] = mf;
                    // debounce: count ce ticks of disagreement, adopt after N of them
                    for (int b = 0; b < 4; b++) begin
                        if (k == 0) mst[k][p][b] = ms2[k][p][b];
                        else if (ms2[k][p][b] == mst[k][p][b]) mcnt[k][p][b] = 0;
                        else if (ce) begin
                            mcnt[k][p][b]++;
                            if (mcnt[k][p][b] == 3) begin
                                mst[k][p][b]  = ms2[k][p][b];
                                mcnt[k][p][b] = 0;
                            end
                        end
                    end
                    ms2[k][p] = ms1[k][p];
                    ms1[k][p] = din[4*p +: 4];
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run) begin
            chk("model_d0", out0, {msel[0][1], msel[0][0]});
            chk("model_d3", out3, {msel[1][1], msel[1][0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        cyc++;
        if (ce_rand)      ce = 1'($urandom_range(0, 1));
        else if (ce_free) ce = 1'b1;
        else              ce = (cyc % 13 == 0);
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    logic [3:0] tog[4];

    initial begin
        rst_n = 1'b0; din = 8'hFF; mode = 4'h0; socd = 1'b0; ce = 1'b1;
        step(); step();
        run = 1;
        chk("reset_d0", out0, 8'h00);
        chk("reset_d3", out3, 8'h00);

        // pass-through latency out of reset
        rst_n = 1'b1;
        step(); step(); step();
        chk("pass_lat3", out0, 8'h00);
        step();
        chk("pass_lat4", out0, 8'hFF);

        // LAST on player 0
        mode = 4'b0001; din = 8'h00; settle(8);
        chk("last_idle", out0, 8'h00);
        din = 8'h01; settle(4); chk("last_r",      out0, 8'h01);
        din = 8'h09; settle(4); chk("last_up",     out0, 8'h08);
        din = 8'h01; settle(4); chk("last_rel_up", out0, 8'h01);
        din = 8'h00; settle(4); chk("last_none",   out0, 8'h00);
        din = 8'h0A; settle(4); chk("last_simul",  out0, 8'h08);

        // FIRST on player 0
        din = 8'h00; mode = 4'b0010; settle(8);
        din = 8'h02; settle(4); chk("first_l",     out0, 8'h02);
        din = 8'h06; settle(4); chk("first_hold",  out0, 8'h02);
        din = 8'h04; settle(4); chk("first_fall",  out0, 8'h04);
        din = 8'h00; settle(4); chk("first_none",  out0, 8'h00);

        // HORIZ + SOCD
        din = 8'h00; mode = 4'b0011; settle(8);
        din = 8'h0A; settle(4); chk("horiz_ul",    out0, 8'h02);
        socd = 1'b1;
        din = 8'h03; settle(4); chk("horiz_socd",  out0, 8'h00);
        socd = 1'b0;
        din = 8'h01; settle(4); chk("horiz_r",     out0, 8'h01);
        din = 8'h03; settle(4); chk("horiz_lnew",  out0, 8'h02);

        // debounce: 2-tick glitch suppressed, 3-tick press accepted
        din = 8'h00; mode = 4'b0000; settle(8);
        ce_free = 0; settle(40);
        din = 8'h01;
        for (int i = 0; i < 26; i++) begin step(); chk("db_glitch", out3, 8'h00); end
        din = 8'h00;
        for (int i = 0; i < 30; i++) begin step(); chk("db_glitch", out3, 8'h00); end
        din = 8'h01; settle(39);
        din = 8'h00; settle(4);
        chk("db_press_d3", out3, 8'h01);
        chk("db_press_d0", out0, 8'h00);
        settle(60);
        chk("db_release", out3, 8'h00);
        ce_free = 1; settle(10);

        // independence and mode change
        mode = 4'b1001; din = 8'h40; settle(8);
        chk("ind_hold", out0, 8'h40);
        tog[0] = 4'h1; tog[1] = 4'h0; tog[2] = 4'h2; tog[3] = 4'h0;
        for (int i = 0; i < 4; i++) begin
            din[3:0] = tog[i]; settle(4);
            chk("ind_toggle", out0, {4'h4, tog[i]});
        end
        din = 8'h50; settle(8);
        chk("ind_first_dr", out0, 8'h40);
        mode = 4'b1101; step();
        chk("mchg_d0", out0, 8'h10);
        chk("mchg_d3", out3, 8'h10);

        // reset mid-operation with directions held
        din = 8'h12; settle(8);
        rst_n = 1'b0; step();
        chk("midrst_d0", out0, 8'h00);
        chk("midrst_d3", out3, 8'h00);
        step(); rst_n = 1'b1; settle(10);
        chk("midrst_refill", out0, 8'h12);

        // randomised soak, checked by the model
        ce_rand = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) din = 8'($urandom);
            if ($urandom_range(0, 40) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 60) == 0) socd = ~socd;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
